// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the CORDIC pipe arbiter.
package cordic_pkg;
   localparam int PKG_WIDTH = 16;
   localparam int MAX_ID_W = 4;
   typedef logic signed [PKG_WIDTH-1:0] data_t;
   typedef logic signed [PKG_WIDTH:0] angle_t;
   typedef struct packed {
      logic valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;
   localparam angle_t ANGLE_ZERO = '0;
endpackage

// File: rtl/cordic_pipe_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant whose pointer moves only on an accepted issue.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_id
);
   localparam int ID_W = $clog2(N);
   logic [ID_W-1:0] ptr_q, ptr_d;
   int idx;
   // Scan from farthest to nearest so the requester closest to the pointer wins.
   always_comb begin
      grant = '0;
      grant_id = '0;
      idx = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         idx = idx >= N ? idx - N : idx;
         if (req[idx]) begin
            grant = '0;
            grant[idx] = 1'b1;
            grant_id = ID_W'(idx);
         end
      end
   end
   assign ptr_d = (advance & |grant) ? (int'(grant_id) == N - 1 ? '0 : grant_id + ID_W'(1)) : ptr_q;
   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end
endmodule

// File: rtl/cordic_pipe_arbiter.sv
// cordic_pipe_arbiter: shares one pipelined CORDIC chain among several requesters,
// tagging each issue so results return to their originator through a single response register.
module cordic_pipe_arbiter
   import cordic_pkg::*;
#(
   parameter int BIT_WIDTH = 16,
   parameter int NUM_REQ = 4,
   parameter int STAGES = 16,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_target_angle,
   input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_x,
   input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_y,
   input  logic [NUM_REQ-1:0]                req_mode,
   output logic                              pipe_start,
   output logic [BIT_WIDTH-1:0]              pipe_target_angle,
   output logic [BIT_WIDTH:0]                pipe_current_angle,
   output logic [BIT_WIDTH-1:0]              pipe_x,
   output logic [BIT_WIDTH-1:0]              pipe_y,
   output logic                              pipe_mode,
   output logic                              pipe_done,
   input  logic [BIT_WIDTH:0]                last_current_angle,
   input  logic [BIT_WIDTH-1:0]              last_x,
   input  logic [BIT_WIDTH-1:0]              last_y,
   input  logic                              last_done,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [ID_W-1:0]                   rsp_id,
   output logic [BIT_WIDTH-1:0]              rsp_x,
   output logic [BIT_WIDTH-1:0]              rsp_y,
   output logic [BIT_WIDTH:0]                rsp_angle,
   output logic                              tag_error
);
   logic                 advance, capture;
   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      grant_id;
   tag_t [STAGES-1:0]    tag_q, tag_d;
   tag_t                 tail;
   logic                 rsp_valid_q, rsp_valid_d, tag_error_q, tag_error_d;
   logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
   logic [BIT_WIDTH-1:0] rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
   logic [BIT_WIDTH:0]   rsp_angle_q, rsp_angle_d;
   // A held, unconsumed result freezes the whole chain so nothing can overrun it.
   assign advance = ~rsp_valid_q | rsp_ready;
   assign pipe_start = advance;
   assign req_ready = advance ? grant : '0;
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk(clk), .reset(reset), .req(req_valid), .advance(advance),
      .grant(grant), .grant_id(grant_id)
   );
   assign pipe_done = |grant;
   assign pipe_x = pipe_done ? req_x[grant_id] : '0;
   assign pipe_y = pipe_done ? req_y[grant_id] : '0;
   assign pipe_target_angle = pipe_done ? req_target_angle[grant_id] : '0;
   assign pipe_mode = pipe_done & req_mode[grant_id];
   assign pipe_current_angle = (BIT_WIDTH+1)'(ANGLE_ZERO);
   assign tail = tag_q[STAGES-1];
   assign capture = advance & last_done;
   always_comb begin
      tag_d = advance ? {tag_q[STAGES-2:0], tag_t'{valid: pipe_done, id: MAX_ID_W'(grant_id)}} : tag_q;
      rsp_valid_d = advance ? last_done : rsp_valid_q;
      rsp_id_d = capture ? ID_W'(tail.id) : rsp_id_q;
      rsp_x_d = capture ? last_x : rsp_x_q;
      rsp_y_d = capture ? last_y : rsp_y_q;
      rsp_angle_d = capture ? last_current_angle : rsp_angle_q;
      tag_error_d = tag_error_q | (advance & (tail.valid ^ last_done));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q <= '0;
         rsp_x_q <= '0;
         rsp_y_q <= '0;
         rsp_angle_q <= '0;
         tag_error_q <= 1'b0;
      end else begin
         tag_q <= tag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q <= rsp_id_d;
         rsp_x_q <= rsp_x_d;
         rsp_y_q <= rsp_y_d;
         rsp_angle_q <= rsp_angle_d;
         tag_error_q <= tag_error_d;
      end
   end
   assign rsp_valid = rsp_valid_q;
   assign rsp_id = rsp_id_q;
   assign rsp_x = rsp_x_q;
   assign rsp_y = rsp_y_q;
   assign rsp_angle = rsp_angle_q;
   assign tag_error = tag_error_q;
endmodule

// File: tb/tb_cordic_pipe_arbiter.sv
// tb_cordic_pipe_arbiter: scoreboard bench with a stand-in chain model driving the last-stage inputs.
module tb_cordic_pipe_arbiter;
   localparam int BW = 16, NR = 4, ST = 16, IW = $clog2(NR);
   typedef struct packed {
      logic [IW-1:0] id;
      logic [BW-1:0] x, y;
      logic [BW:0]   a;
   } rsp_t;

   logic clk = 0, reset = 1, rsp_ready = 1, inj = 0;
   logic [NR-1:0] req_valid = '0, req_ready, req_mode = '0;
   logic [NR-1:0][BW-1:0] req_target_angle = '0, req_x = '0, req_y = '0;
   logic pipe_start, pipe_mode, pipe_done, last_done, rsp_valid, tag_error;
   logic [BW-1:0] pipe_target_angle, pipe_x, pipe_y, last_x, last_y, rsp_x, rsp_y;
   logic [BW:0] pipe_current_angle, last_current_angle, rsp_angle;
   logic [IW-1:0] rsp_id;

   cordic_pipe_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .STAGES(ST)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_target_angle(req_target_angle), .req_x(req_x), .req_y(req_y), .req_mode(req_mode),
      .pipe_start(pipe_start), .pipe_target_angle(pipe_target_angle),
      .pipe_current_angle(pipe_current_angle), .pipe_x(pipe_x), .pipe_y(pipe_y),
      .pipe_mode(pipe_mode), .pipe_done(pipe_done), .last_current_angle(last_current_angle),
      .last_x(last_x), .last_y(last_y), .last_done(last_done), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
      .rsp_angle(rsp_angle), .tag_error(tag_error)
   );

   always #5 clk = ~clk;

   int compared = 0, failed = 0, pops = 0, cyc = 0;
   int mptr = 0, gap_exp = 0, epoch = 0, my_epoch = 0, last_pop = -1;
   int seq[NR] = '{default: 0};
   int tot[NR] = '{default: 0};
   logic [NR-1:0] acc = '0;
   bit hold_v = 0, ign = 0, use_fixed = 0, sparse = 0;
   rsp_t held;
   rsp_t sb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Stand-in for the CORDIC chain: a fixed transform followed by an ST-deep delay line.
   function automatic rsp_t chain_ref(input logic [IW-1:0] id, input logic [BW-1:0] x, y, a, input logic m);
      rsp_t r;
      r.id = id;
      r.x = x + 16'h0101;
      r.y = y ^ a;
      r.a = {a[BW-1], a} + {{BW{1'b0}}, m};
      return r;
   endfunction

   logic [BW-1:0] cx[ST], cy[ST];
   logic [BW:0] ca[ST];
   logic cd[ST];
   always @(posedge clk) begin
      rsp_t r;
      r = chain_ref('0, pipe_x, pipe_y, pipe_target_angle, pipe_mode);
      if (reset) begin
         for (int s = 0; s < ST; s++) begin
            cx[s] <= '0; cy[s] <= '0; ca[s] <= '0; cd[s] <= 1'b0;
         end
      end else if (pipe_start) begin
         cx[0] <= r.x; cy[0] <= r.y; ca[0] <= r.a; cd[0] <= pipe_done;
         for (int s = 1; s < ST; s++) begin
            cx[s] <= cx[s-1]; cy[s] <= cy[s-1]; ca[s] <= ca[s-1]; cd[s] <= cd[s-1];
         end
      end
   end
   assign last_x = cx[ST-1];
   assign last_y = cy[ST-1];
   assign last_current_angle = ca[ST-1];
   assign last_done = cd[ST-1] | inj;

   // Requester driver: each requester issues tot[i]-seq[i] more items, holding data until accepted.
   always @(posedge clk) begin
      cyc++;
      #1;
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) seq[i]++;
         req_valid[i] = seq[i] < tot[i] && (!sparse || cyc % 3 == 0);
         req_x[i] = (use_fixed && i == 2) ? 16'h4DBA : 16'(16'h0123 + i * 16'h1000 + seq[i] * 16'h0011);
         req_y[i] = (use_fixed && i == 2) ? 16'h0000 : 16'((seq[i] * 16'h0101) ^ i);
         req_target_angle[i] = (use_fixed && i == 2) ? 16'h2000 : 16'(i * 16'h0400 + seq[i] * 3);
         req_mode[i] = (use_fixed && i == 2) ? 1'b0 : 1'(seq[i] + i);
      end
   end

   // Monitor: arbitration model pushes expectations; response handshakes pop and compare.
   always @(negedge clk) begin
      logic [NR-1:0] g;
      int gi, idx;
      bit adv;
      rsp_t cur, e;
      cur = '{rsp_id, rsp_x, rsp_y, rsp_angle};
      if (reset) begin
         sb.delete();
         mptr = 0;
         hold_v = 0;
         acc = '0;
      end else begin
         if (epoch != my_epoch) begin
            my_epoch = epoch;
            last_pop = -1;
         end
         adv = !rsp_valid || rsp_ready;
         if (hold_v) chk("hold_stable", cur, held);
         hold_v = rsp_valid && !rsp_ready;
         held = cur;
         if (rsp_valid && rsp_ready && !ign) begin
            chk("rsp_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("rsp", cur, e);
            end
            if (gap_exp > 0 && last_pop >= 0) chk("rsp_gap", cyc - last_pop, gap_exp);
            last_pop = cyc;
            pops++;
         end
         g = '0;
         gi = 0;
         for (int k = NR - 1; k >= 0; k--) begin
            idx = (mptr + k) % NR;
            if (req_valid[idx]) begin
               g = '0;
               g[idx] = 1'b1;
               gi = idx;
            end
         end
         chk("pipe_start", pipe_start, adv);
         chk("req_ready", req_ready, adv ? g : '0);
         chk("pipe_done", pipe_done, |g);
         chk("pipe_cur_angle", pipe_current_angle, 0);
         acc = adv ? g : '0;
         if (|acc) begin
            sb.push_back(chain_ref(IW'(gi), req_x[gi], req_y[gi], req_target_angle[gi], req_mode[gi]));
            mptr = (gi + 1) % NR;
         end
      end
   end

   function automatic bit all_done();
      foreach (seq[i]) if (seq[i] != tot[i]) return 0;
      return sb.size() == 0 && !rsp_valid;
   endfunction

   task automatic wait_idle(input string nm, input int budget);
      bit ok = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(posedge clk);
         ok = all_done();
      end
      chk(nm, ok, 1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: got no finish required finish within budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, lat;
      bit got;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_x", rsp_x, 0);
      chk("rst_y", rsp_y, 0);
      chk("rst_angle", rsp_angle, 0);
      chk("rst_tag_error", tag_error, 0);

      // single request with known vector, latency and routing
      @(posedge clk); #1;
      use_fixed = 1;
      tot[2] = seq[2] + 1;
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         got = req_ready[2];
      end
      chk("t1_accept", got, 1);
      lat = 0;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         lat++;
         got = rsp_valid;
      end
      chk("t1_latency", lat, ST + 1);
      chk("t1_id", rsp_id, 2);
      chk("t1_x", rsp_x, 16'h4EBB);
      chk("t1_y", rsp_y, 16'h2000);
      chk("t1_angle", rsp_angle, 17'h02000);
      use_fixed = 0;
      wait_idle("t1_idle", 60);

      // all four requesters continuously: round-robin order, back-to-back results
      p0 = pops;
      gap_exp = 1;
      epoch++;
      for (int i = 0; i < NR; i++) tot[i] = seq[i] + 3;
      wait_idle("t2_idle", 100);
      chk("t2_count", pops - p0, 12);

      // backpressure mid-stream
      p0 = pops;
      gap_exp = 0;
      sparse = 1;
      for (int i = 0; i < NR; i++) tot[i] = seq[i] + 2;
      got = 0;
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         got = rsp_valid;
      end
      chk("t3_first_rsp", got, 1);
      @(posedge clk); #1 rsp_ready = 0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t3_stall_start", pipe_start, 0);
      chk("t3_stall_ready", req_ready, 0);
      chk("t3_stall_valid", rsp_valid, 1);
      repeat (5) @(posedge clk);
      #1 rsp_ready = 1;
      wait_idle("t3_idle", 150);
      chk("t3_count", pops - p0, 8);

      // sparse single requester: bubbles between results spaced three cycles
      p0 = pops;
      gap_exp = 3;
      epoch++;
      tot[1] = seq[1] + 5;
      wait_idle("t4_idle", 100);
      chk("t4_count", pops - p0, 5);
      chk("t4_tag_error", tag_error, 0);
      sparse = 0;
      gap_exp = 0;

      // reset with requests in flight
      p0 = pops;
      tot[0] = seq[0] + 2;
      tot[1] = seq[1] + 2;
      tot[2] = seq[2] + 1;
      got = 0;
      for (int n = 0; n < 30 && !got; n++) begin
         @(posedge clk);
         got = seq[0] == tot[0] && seq[1] == tot[1] && seq[2] == tot[2];
      end
      chk("t5_issued", got, 1);
      repeat (3) @(posedge clk);
      #1 reset = 1;
      tot[1] = seq[1] + 1;
      tot[3] = seq[3] + 1;
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_ptr_grant", req_ready, 4'b0010);
      wait_idle("t5_idle", 80);
      chk("t5_count", pops - p0, 2);
      chk("t5_tag_error", tag_error, 0);

      // done asserted on a bubble slot
      ign = 1;
      @(posedge clk); #1 inj = 1;
      @(posedge clk); #1 inj = 0;
      @(negedge clk);
      chk("t6_tag_error_set", tag_error, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t6_tag_error_sticky", tag_error, 1);
      @(posedge clk); #1 reset = 1;
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("t6_tag_error_clear", tag_error, 0);
      chk("t6_rsp_valid", rsp_valid, 0);
      ign = 0;
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule

// File: doc/cordic_pipe_arbiter.md
Name: cordic_pipe_arbiter

Overview:
Shares one pipelined CORDIC chain, a cascade of STAGES cordic stages, between NUM_REQ independent requesters.
- Round-robin arbitration, one issue per pipeline advance.
- A tag shift register runs in lockstep with the chain so each result is routed back with its requester ID.
- One output holding register with valid/ready backpressure, enforced by freezing the chain's start.
- Sits between the CORDIC clients and the first/last pipeline stage.

Parameters:
BIT_WIDTH, 16, data/angle width, identical to the chain's BIT_WIDTH
NUM_REQ, 4, number of requesters (2..16)
STAGES, 16, number of stages in the attached chain (= pipeline depth in advances)
ID_W (localparam), $clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  [NUM_REQ-1:0]  request valid per requester
req_ready  out  [NUM_REQ-1:0]  request accepted this cycle
req_target_angle  in  [NUM_REQ-1:0][BIT_WIDTH-1:0]  signed target angle
req_x, req_y  in  [NUM_REQ-1:0][BIT_WIDTH-1:0]  signed initial vector
req_mode  in  [NUM_REQ-1:0]  0 = rotation, 1 = vectoring
pipe_start  out  1  start to every stage
pipe_target_angle  out  BIT_WIDTH  to first stage
pipe_current_angle  out  BIT_WIDTH+1  to first stage, constant 0
pipe_x, pipe_y  out  BIT_WIDTH  to first stage
pipe_mode, pipe_done  out  1  to first stage
last_current_angle  in  BIT_WIDTH+1  last stage output angle
last_x, last_y  in  BIT_WIDTH  last stage outputs
last_done  in  1  last stage done
rsp_valid  out  1  result held
rsp_ready  in  1  consumer accepts
rsp_id  out  ID_W  originating requester
rsp_x, rsp_y  out  BIT_WIDTH  result vector
rsp_angle  out  BIT_WIDTH+1  result angle
tag_error  out  1  sticky tag/done mismatch

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: all registered state 0.
  - rsp_valid=0, rsp_id/x/y/angle=0, tag_error=0.
  - Tag SR all invalid, RR pointer=0.
- The chain shares the same reset. Reset mid-operation discards all in-flight work; no responses are produced for it.

Advance and backpressure:
- advance = ~rsp_valid | rsp_ready. pipe_start = advance (combinational).
- When advance=0, the chain, tag SR, RR pointer and request acceptance all freeze.

Arbitration:
- Round-robin over req_valid, starting at the RR pointer.
- grant is one-hot or zero. req_ready[i] = advance & grant[i].
- On an accepted grant to i, the pointer becomes (i+1) mod NUM_REQ; otherwise it is unchanged.
- Requesters hold valid and data stable until ready. Dropping valid before ready is legal; the request is simply not issued.

First-stage drive (combinational from grant):
- pipe_done = |grant.
- pipe_x, pipe_y, pipe_target_angle, pipe_mode come from the granted requester.
- pipe_current_angle = 0.
- With no grant, data outputs are 0 and pipe_done=0, so a bubble propagates.

Tag SR:
- STAGES entries of {valid, id}. On advance: shift, entry0 <= {|grant, granted id}.
- The last entry lines up with last_* outputs.

Capture, on advance:
- If last_done, load rsp_* from last_* and the tail tag id; rsp_valid <= 1.
- Otherwise rsp_valid <= 0.
- If the tail tag valid != last_done, set tag_error (sticky until reset).
- If rsp_valid & rsp_ready & ~last_done, rsp_valid clears.

Latency and throughput:
- Accept at edge t; rsp_valid rises after STAGES+1 advancing edges.
- Throughput is 1 result per cycle when rsp_ready is held high.

Boundary conditions:
- Simultaneous drain and capture: rsp is overwritten in the same cycle with no bubble.
- All requesters idle: the chain runs on bubbles.
- A single active requester is granted every advance.
- NUM_REQ not a power of 2: pointer wrap is explicit (mod NUM_REQ).

Decomposition:
- Package cordic_pkg:
  - angle_t / data_t typedefs sized by BIT_WIDTH.
  - tag_t struct {valid, id}.
  - Constant ANGLE_ZERO.
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports clk, reset, req, advance, grant (one-hot), grant_id.
  - Owns the pointer.
- Top module: tag SR, muxing, response register.

Test Plan:
- Single request, requester 2, x=0x4DBA, y=0, angle=0x2000, mode=0, rsp_ready=1 → rsp_valid exactly STAGES+1 edges after accept, rsp_id=2; rsp_x/rsp_y equal a standalone-chain reference model.
- All 4 requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0,…; responses return in the same id order, back-to-back with no bubbles.
- Backpressure: stream 8 requests, hold rsp_ready=0 for 10 cycles mid-stream → pipe_start=0 and req_ready=0 while rsp_valid held; rsp value stable; all 8 responses delivered, none lost or duplicated.
- Sparse traffic: req_valid on requester 1 every 3rd cycle → bubbles propagate; rsp_valid pulses spaced 3 cycles apart; tag_error stays 0.
- Reset asserted with 5 requests in flight → next cycle rsp_valid=0 and pointer=0; no responses for the flushed requests; a new request after reset returns normally.
- Fault injection: force last_done=1 on a bubble slot → tag_error=1 and stays set until reset.
